// File: rtl/perip_tono.sv
// perip_tono: four-voice square-wave tone generator with a 2-bit PWM mixer.
// Ports: clk, reset (async, active-high), bus cs/addr/wr/wdata, audio_out, voice_active.
// Optional readback (rd/rdata) is enabled by defining PERIP_TONO_READBACK_EN.
`timescale 1ns/1ps
module perip_tono #(
  parameter int WIDTH = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        wr,
  input  logic [31:0] wdata,
`ifdef PERIP_TONO_READBACK_EN
  input  logic        rd,
  output logic [31:0] rdata,
`endif
  output logic        audio_out,
  output logic [3:0]  voice_active
);

  logic [WIDTH-1:0] period     [4];
  logic [WIDTH-1:0] period_nxt [4];
  logic [WIDTH-1:0] cnt        [4];
  logic [3:0]       gate;
  logic [3:0]       gate_nxt;
  logic [3:0]       sq;
  logic [3:0]       per_we;
  logic [3:0]       act_nxt;
  logic             gate_we;
  logic [1:0]       pwm_cnt;
  logic [2:0]       lvl_q;
  logic [2:0]       level;

  always_comb begin
    gate_we  = cs && wr && (addr == 4'h4);
    gate_nxt = gate_we ? wdata[3:0] : gate;
    for (int i = 0; i < 4; i++) begin
      per_we[i]     = cs && wr && (addr == 4'(i));
      period_nxt[i] = per_we[i] ? wdata[WIDTH-1:0] : period[i];
      act_nxt[i]    = gate_nxt[i] && (period_nxt[i] != '0);
    end
  end

  assign level = 3'(sq[0]) + 3'(sq[1]) + 3'(sq[2]) + 3'(sq[3]);

  // A voice counts only while active before and after the edge;
  // a period write or deactivation restarts it from phase zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gate         <= '0;
      voice_active <= '0;
      sq           <= '0;
      for (int i = 0; i < 4; i++) begin
        period[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      gate         <= gate_nxt;
      voice_active <= act_nxt;
      for (int i = 0; i < 4; i++) begin
        period[i] <= period_nxt[i];
        if (per_we[i] || !voice_active[i] || !act_nxt[i]) begin
          cnt[i] <= '0;
          sq[i]  <= 1'b0;
        end else if (cnt[i] == period[i] - WIDTH'(1)) begin
          cnt[i] <= '0;
          sq[i]  <= ~sq[i];
        end else begin
          cnt[i] <= cnt[i] + WIDTH'(1);
        end
      end
    end
  end

  // Level is sampled once per 4-cycle frame so each frame
  // carries exactly lvl_q high cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt   <= '0;
      lvl_q     <= '0;
      audio_out <= 1'b0;
    end else begin
      pwm_cnt   <= pwm_cnt + 2'd1;
      audio_out <= {1'b0, pwm_cnt} < lvl_q;
      if (pwm_cnt == 2'd3)
        lvl_q <= level;
    end
  end

`ifdef PERIP_TONO_READBACK_EN
  always_comb begin
    rdata = 32'h0;
    if (cs && rd) begin
      case (addr)
        4'h0, 4'h1,
        4'h2, 4'h3: rdata = 32'(period[addr[1:0]]);
        4'h4:       rdata = {28'h0, gate};
        default:    rdata = 32'hDEADBEEF;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_perip_tono.sv
// tb_perip_tono: directed self-checking bench for perip_tono.
// Edge Ek is the k-th rising edge after reset release.
`timescale 1ns/1ps
module tb_perip_tono;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic [3:0]  addr;
  logic        wr;
  logic [31:0] wdata;
  logic        audio_out;
  logic [3:0]  voice_active;
`ifdef PERIP_TONO_READBACK_EN
  logic        rd;
  logic [31:0] rdata;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  perip_tono #(.WIDTH(20)) dut (
    .clk          (clk),
    .reset        (reset),
    .cs           (cs),
    .addr         (addr),
    .wr           (wr),
    .wdata        (wdata),
`ifdef PERIP_TONO_READBACK_EN
    .rd           (rd),
    .rdata        (rdata),
`endif
    .audio_out    (audio_out),
    .voice_active (voice_active)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    cs    = 1'b1;
    wr    = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    cs    = 1'b0;
    wr    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

`ifdef PERIP_TONO_READBACK_EN
  task automatic rd_chk(input string tag, input logic [3:0] a,
                        input logic sel, input logic [31:0] exp);
    cs   = sel;
    rd   = 1'b1;
    addr = a;
    #1;
    check(tag, rdata, exp);
    cs   = 1'b0;
    rd   = 1'b0;
  endtask
`endif

  initial begin
    cs    = 1'b0;
    wr    = 1'b0;
    addr  = '0;
    wdata = '0;
`ifdef PERIP_TONO_READBACK_EN
    rd    = 1'b0;
`endif

    // reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst_audio", audio_out, 0);
    check("rst_active", voice_active, 0);
`ifdef PERIP_TONO_READBACK_EN
    for (int a = 0; a < 5; a++)
      rd_chk("rst_rd", 4'(a), 1'b1, 0);
`endif
    reset = 1'b0;

    // single voice, period 3: audio high after E9,E13,E21,E25
    wr_reg(4'h0, 32'd3);
    wr_reg(4'h4, 32'h1);
    check("v0_active", voice_active, 4'h1);
    for (int k = 3; k <= 28; k++) begin
      tick();
      check($sformatf("v0_aud_e%0d", k), audio_out,
            32'(k == 9 || k == 13 || k == 21 || k == 25));
    end

    // full mix, all periods 16, gate at E5: level 4 for E21..E36
    do_reset();
    for (int i = 0; i < 4; i++)
      wr_reg(4'(i), 32'd16);
    wr_reg(4'h4, 32'hF);
    check("mix_active", voice_active, 4'hF);
    for (int k = 6; k <= 60; k++) begin
      tick();
      check($sformatf("mix_aud_e%0d", k), audio_out,
            32'((k >= 25 && k <= 40) || k >= 57));
    end

    // reset mid-tone clears outputs at once and blocks a bus write
    reset = 1'b1;
    #1;
    check("mid_rst_audio", audio_out, 0);
    check("mid_rst_active", voice_active, 0);
    cs    = 1'b1;
    wr    = 1'b1;
    addr  = 4'h4;
    wdata = 32'hF;
    tick();
    check("rst_wr_active", voice_active, 0);
    cs    = 1'b0;
    wr    = 1'b0;
    reset = 1'b0;
    tick();
    check("post_rst_active", voice_active, 0);

    // phase restart: voice 1 period 10, rewritten to 5 at E14
    do_reset();
    wr_reg(4'h1, 32'd10);
    wr_reg(4'h4, 32'h2);
    check("ph_active", voice_active, 4'h2);
    for (int k = 3; k <= 13; k++) begin
      tick();
      check($sformatf("ph_aud_e%0d", k), audio_out, 0);
    end
    wr_reg(4'h1, 32'd5);
    check("ph_active2", voice_active, 4'h2);
    for (int k = 15; k <= 44; k++) begin
      tick();
      check($sformatf("ph_aud_e%0d", k), audio_out,
            32'(k == 21 || k == 25 || k == 33 || k == 41));
    end

    // boundaries
    do_reset();
    wr_reg(4'h4, 32'h1);
    check("zero_per_active", voice_active, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("zero_per_audio", audio_out, 0);
    end
    wr_reg(4'h4, 32'hF);
    check("gate_f_active", voice_active, 0);
    wr_reg(4'h7, 32'h1);
    check("addr7_active", voice_active, 0);
`ifdef PERIP_TONO_READBACK_EN
    rd_chk("addr7_rd3", 4'h3, 1'b1, 0);
    rd_chk("addr7_rd4", 4'h4, 1'b1, 32'hF);
`endif
    wr_reg(4'h0, 32'hFFFFFFFF);
    check("max_per_active", voice_active, 4'h1);
`ifdef PERIP_TONO_READBACK_EN
    rd_chk("max_per_rd", 4'h0, 1'b1, 32'h000FFFFF);
`endif
    wr_reg(4'h2, 32'h12345);
    check("p2_active", voice_active, 4'h5);
    wr_reg(4'h0, 32'hFFF00000);
    check("trunc_active", voice_active, 4'h4);
`ifdef PERIP_TONO_READBACK_EN
    rd_chk("rd_p2", 4'h2, 1'b1, 32'h00012345);
    rd_chk("rd_bad", 4'h9, 1'b1, 32'hDEADBEEF);
    rd_chk("rd_nocs", 4'h2, 1'b0, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
